// File: rtl/mustang_period_meter.sv
// mustang_period_meter: measures period and high time of a slow asynchronous
// square wave in CLK cycles, one valid strobe per completed period.
`default_nettype none

module mustang_period_meter #(
  parameter int WIDTH       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             sig_in,
  input  logic             clr,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             overflow
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t               state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                 prev;
  logic                 s;
  logic                 rise;
  logic [WIDTH-1:0]     cnt, cnt_nxt;
  logic [WIDTH-1:0]     hcnt, hcnt_nxt;
  logic [WIDTH-1:0]     period_nxt, high_nxt;
  logic                 valid_nxt, locked_nxt, ovf_event;

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~prev;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig_in};
      prev <= s;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      hcnt      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hcnt      <= hcnt_nxt;
      period    <= period_nxt;
      high_time <= high_nxt;
      valid     <= valid_nxt;
      locked    <= locked_nxt;
    end
  end

  // A new overflow event takes precedence over a simultaneous clear.
  always_ff @(posedge CLK) begin
    if (RST)
      overflow <= 1'b0;
    else if (ovf_event)
      overflow <= 1'b1;
    else if (clr)
      overflow <= 1'b0;
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    hcnt_nxt   = hcnt;
    period_nxt = period;
    high_nxt   = high_time;
    valid_nxt  = 1'b0;
    locked_nxt = locked;
    ovf_event  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          cnt_nxt   = ONE;
          hcnt_nxt  = ONE;
          state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_nxt = cnt;
          high_nxt   = hcnt;
          valid_nxt  = 1'b1;
          locked_nxt = 1'b1;
          cnt_nxt    = ONE;
          hcnt_nxt   = ONE;
        end else if (cnt == CNT_MAX) begin
          ovf_event  = 1'b1;
          locked_nxt = 1'b0;
          state_nxt  = IDLE;
          cnt_nxt    = '0;
          hcnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ONE;
          if (s)
            hcnt_nxt = hcnt + ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mustang_period_meter.sv
// tb_mustang_period_meter: two instances (wide and 4-bit counters) driven by a
// shared stimulus, each checked against a timestamp-based reference model.
`default_nettype none

module tb_mustang_period_meter;

  typedef struct {
    int per;
    int hi;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic sig_in;
  logic clr;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int     W     = (g == 0) ? 24 : 4;
    localparam int     SS    = (g == 0) ? 2 : 3;
    localparam longint LIMIT = (longint'(1) << W) - 1;

    logic [W-1:0] period, high_time;
    logic         valid, locked, overflow;

    mustang_period_meter #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
      .CLK      (clk),
      .RST      (rst),
      .sig_in   (sig_in),
      .clr      (clr),
      .period   (period),
      .high_time(high_time),
      .valid    (valid),
      .locked   (locked),
      .overflow (overflow)
    );

    // Model: s at posedge n is sig_in as sampled SS posedges earlier; a
    // measurement is the distance between rise timestamps.
    exp_t   q[$];
    bit     hist[SS+1];
    bit     armed, m_ovf, m_lck;
    longint n = 0, last_rise = 0;
    int     hc, held_per, held_hi;

    always @(posedge clk) begin
      bit s_now, s_prev, ev;
      n++;
      if (rst) begin
        foreach (hist[i]) hist[i] = 1'b0;
        armed = 0; m_ovf = 0; m_lck = 0; hc = 0;
        held_per = 0; held_hi = 0;
        q.delete();
      end else begin
        s_now  = hist[SS-1];
        s_prev = hist[SS];
        ev     = 0;
        if (s_now && !s_prev) begin
          if (armed) begin
            q.push_back('{per: int'(n - last_rise), hi: hc});
            held_per = int'(n - last_rise);
            held_hi  = hc;
            m_lck    = 1;
          end
          armed = 1; last_rise = n; hc = 1;
        end else if (armed) begin
          if (n - last_rise == LIMIT) begin
            armed = 0; m_lck = 0; hc = 0; ev = 1;
          end else if (s_now) begin
            hc++;
          end
        end
        if (ev) m_ovf = 1;
        else if (clr) m_ovf = 0;
        for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = sig_in;
      end
    end

    always @(negedge clk) begin
      exp_t e;
      if (valid) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL inst%0d spurious_valid got=1 want=0 t=%0t", g, $time);
        end else begin
          e = q.pop_front();
          total++;
          if (period !== W'(e.per)) begin
            bad++;
            $display("FAIL inst%0d period got=%0d want=%0d t=%0t", g, period, e.per, $time);
          end
          total++;
          if (high_time !== W'(e.hi)) begin
            bad++;
            $display("FAIL inst%0d high_time got=%0d want=%0d t=%0t", g, high_time, e.hi, $time);
          end
        end
      end else begin
        total++;
        if (q.size() != 0) begin
          bad++;
          $display("FAIL inst%0d missed_valid got=0 want=1 t=%0t", g, $time);
          void'(q.pop_front());
        end
        total++;
        if (period !== W'(held_per) || high_time !== W'(held_hi)) begin
          bad++;
          $display("FAIL inst%0d hold got=%0d/%0d want=%0d/%0d t=%0t",
                   g, period, high_time, held_per, held_hi, $time);
        end
      end
      total++;
      if (overflow !== m_ovf) begin
        bad++;
        $display("FAIL inst%0d overflow got=%0b want=%0b t=%0t", g, overflow, m_ovf, $time);
      end
      total++;
      if (locked !== m_lck) begin
        bad++;
        $display("FAIL inst%0d locked got=%0b want=%0b t=%0t", g, locked, m_lck, $time);
      end
    end
  end

  // c: 0/1 drives clr constantly, 2 pulses it at random.
  task automatic cycles(input int cnt, input bit v, input int c);
    repeat (cnt) begin
      @(negedge clk);
      sig_in = v;
      clr    = (c == 2) ? ($urandom_range(0, 15) == 0) : c[0];
    end
  endtask

  task automatic wave(input int p, input int h, input int reps, input int c);
    repeat (reps) begin
      cycles(h, 1'b1, c);
      cycles(p - h, 1'b0, c);
    end
  endtask

  initial begin
    int p, h;
    rst = 1'b1; sig_in = 1'b0; clr = 1'b0;
    cycles(3, 1'b0, 0);
    rst = 1'b0;
    cycles(2, 1'b0, 0);

    wave(10, 4, 6, 0);           // steady 10/4
    wave(7, 3, 6, 0);            // switch to 7/3
    cycles(25, 1'b0, 0);         // stuck low: narrow instance overflows
    wave(6, 3, 5, 0);            // relock, overflow stays set
    cycles(1, 1'b0, 1);          // clear overflow
    cycles(2, 1'b0, 0);
    wave(6, 3, 2, 0);
    cycles(30, 1'b0, 1);         // clr held across the overflow event
    cycles(2, 1'b0, 0);
    wave(10, 4, 3, 0);
    cycles(3, 1'b1, 0);          // reset mid-measurement
    rst = 1'b1;
    cycles(1, 1'b1, 0);
    rst = 1'b0;
    cycles(1, 1'b1, 0);
    cycles(6, 1'b0, 0);
    wave(10, 4, 4, 0);
    cycles(25, 1'b1, 0);         // stuck high
    cycles(4, 1'b0, 0);
    wave(16, 8, 6, 0);           // divider model, toggle every 8

    repeat (30) begin
      p = $urandom_range(4, 14);
      h = $urandom_range(2, p - 2);
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b1;
        cycles(1, 1'b0, 0);
        rst = 1'b0;
      end
      wave(p, h, $urandom_range(2, 5), 2);
      if ($urandom_range(0, 5) == 0) cycles($urandom_range(10, 20), 1'b0, 2);
    end

    cycles(20, 1'b0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
